axi4_rd_arbiter: RTL and testbench
==================================

// Module: axi4_rd_arbiter
// PURPOSE
//  Shares one downstream AXI4 read port (AR + R channels) among NUM_MST upstream masters.
//  Round-robin AR arbitration, with a per-master outstanding-burst limit.
//  Prefixes ARID with the master index and routes R beats back by that RID prefix.
//  Sits between the DMA/CPU read masters and the fabric/memory read port.
// PARAMETERS
//  NUM_MST   4   number of upstream masters (2..16)
//  AW        32  address width
//  DW        64  data width
//  IDW       4   upstream ID width
//  MAX_OUTS  4   max outstanding read bursts per master (1..15)
//  MW        derived: $clog2(NUM_MST), minimum 1; master-index width
// PORTS
//  clk        in   1            clock
//  rst        in   1            synchronous active-high reset
//  s_arvalid  in   NUM_MST      per-master AR valid
//  s_araddr   in   NUM_MST*AW   packed; master i at [i*AW +: AW]
//  s_arid     in   NUM_MST*IDW  packed per-master ARID
//  s_arlen    in   NUM_MST*8    packed per-master ARLEN
//  s_arready  out  NUM_MST      per-master AR ready
//  s_rvalid   out  NUM_MST      per-master R valid
//  s_rdata    out  DW           broadcast R data
//  s_rid      out  IDW          m_rid[IDW-1:0]
//  s_rresp    out  2            broadcast RRESP
//  s_rlast    out  1            broadcast RLAST
//  s_rready   in   NUM_MST      per-master R ready
//  m_arvalid  out  1            downstream AR valid
//  m_araddr   out  AW           granted master's address
//  m_arid     out  MW+IDW       {grant index, s_arid[grant]}
//  m_arlen    out  8            granted master's ARLEN
//  m_arready  in   1            downstream AR ready
//  m_rvalid   in   1            downstream R valid
//  m_rdata    in   DW           downstream R data
//  m_rid      in   MW+IDW       downstream RID
//  m_rresp    in   2            downstream RRESP
//  m_rlast    in   1            downstream RLAST
//  m_rready   out  1            downstream R ready
//  rid_err    out  1            one-cycle pulse: R beat accepted with index >= NUM_MST
// BEHAVIOUR
//  Reset values:
//   - state=IDLE, rr_ptr=0, all outs_cnt[i]=0.
//   - m_arvalid=0, s_arready=0, rid_err=0.
//  Eligibility: elig[i] = s_arvalid[i] && outs_cnt[i] < MAX_OUTS.
//  IDLE:
//   - if any elig, choose the first elig index at or after rr_ptr (wrapping).
//   - register it as gnt; next state GRANT.
//   - m_arvalid=0 in IDLE.
//  GRANT:
//   - m_arvalid=1; m_araddr/m_arlen/m_arid are muxed combinationally from gnt.
//   - s_arready[gnt] = m_arready; all other s_arready bits are 0.
//   - on m_arvalid && m_arready: outs_cnt[gnt]++, rr_ptr = (gnt+1) mod NUM_MST, go to IDLE.
//   - grant is held until the handshake (AXI valid-stability); no preemption.
//   - throughput: at most one AR per 2 cycles.
//  R path, fully combinational, 0 latency:
//   - idx = m_rid[MW+IDW-1:IDW].
//   - s_rvalid[idx] = m_rvalid; m_rready = s_rready[idx]; other s_rvalid bits are 0.
//  Completion: on m_rvalid && m_rready && m_rlast, outs_cnt[idx]--.
//   - same-cycle AR handshake and completion on one master: count unchanged.
//  Invalid RID index (idx >= NUM_MST):
//   - m_rready=1 so the beat is drained; no s_rvalid asserted.
//   - rid_err=1 for that beat (registered, next cycle); outs_cnt unchanged.
//  Counters never wrap: 0 and MAX_OUTS are hard bounds.
//   - decrement at 0 is ignored (also flagged via rid_err).
//  Reset mid-GRANT: m_arvalid is low from the first cycle after rst is sampled;
//   in-flight counts are discarded.
// CONFIGURATION
//  Macro AXI_ARB_QOS_EN:
//   - defined: adds ports s_arqos (in, NUM_MST*4) and m_arqos (out, 4).
//   - defined: IDLE picks the elig master with the highest arqos; ties are broken
//     round-robin from rr_ptr. m_arqos = s_arqos[gnt].
//   - undefined: those ports are absent; pure round-robin.
// TESTING
//  1. rr_ptr=0, s_arvalid=4'b0101 -> gnt 0 first (m_arid={2'd0,id0}), then gnt 2; rr_ptr=3.
//  2. MAX_OUTS=4; master1 issues 4 ARs with no R -> 5th never granted;
//     one R beat rid={2'd1,x}, rlast=1 -> 5th granted.
//  3. ARLEN=3 burst, rid={2'd2,4'h5}, s_rready[2] low 2 cycles ->
//     only s_rvalid[2] high, m_rready=0 while stalled, s_rid=4'h5, 4 beats delivered.
//  4. NUM_MST=3, m_rid index=3, m_rvalid=1 -> m_rready=1, s_rvalid=0, rid_err pulses 1 cycle.
//  5. rst=1 in GRANT with m_arready=0 -> next cycle m_arvalid=0, s_arready=0, outs_cnt all 0.
//  6. QOS_EN: m0 qos=2, m1 qos=9 both valid -> m1 granted first;
//     equal qos -> round-robin order kept.

Source files
------------

// File: rtl/axi4_rd_arbiter.sv
// axi4_rd_arbiter: shares one downstream AXI4 read port (AR + R) among
// NUM_MST upstream masters. Round-robin AR arbitration with a per-master
// outstanding-burst limit; ARID is prefixed with the master index and R beats
// are routed back by that RID prefix.
// Optional build macro AXI_ARB_QOS_EN: adds s_arqos/m_arqos and makes the
// arbiter prefer the highest-QoS eligible master (ties resolved round-robin).
module axi4_rd_arbiter #(
  parameter int NUM_MST  = 4,
  parameter int AW       = 32,
  parameter int DW       = 64,
  parameter int IDW      = 4,
  parameter int MAX_OUTS = 4,
  localparam int MW      = (NUM_MST > 1) ? $clog2(NUM_MST) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_MST-1:0]     s_arvalid,
  input  logic [NUM_MST*AW-1:0]  s_araddr,
  input  logic [NUM_MST*IDW-1:0] s_arid,
  input  logic [NUM_MST*8-1:0]   s_arlen,
`ifdef AXI_ARB_QOS_EN
  input  logic [NUM_MST*4-1:0]   s_arqos,
  output logic [3:0]             m_arqos,
`endif
  output logic [NUM_MST-1:0]     s_arready,
  output logic [NUM_MST-1:0]     s_rvalid,
  output logic [DW-1:0]          s_rdata,
  output logic [IDW-1:0]         s_rid,
  output logic [1:0]             s_rresp,
  output logic                   s_rlast,
  input  logic [NUM_MST-1:0]     s_rready,
  output logic                   m_arvalid,
  output logic [AW-1:0]          m_araddr,
  output logic [MW+IDW-1:0]      m_arid,
  output logic [7:0]             m_arlen,
  input  logic                   m_arready,
  input  logic                   m_rvalid,
  input  logic [DW-1:0]          m_rdata,
  input  logic [MW+IDW-1:0]      m_rid,
  input  logic [1:0]             m_rresp,
  input  logic                   m_rlast,
  output logic                   m_rready,
  output logic                   rid_err
);

  localparam int CW = $clog2(MAX_OUTS + 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t        state_reg, state_next;
  logic [MW-1:0] gnt_reg, gnt_next;
  logic [MW-1:0] rr_ptr_reg, rr_ptr_next;
  logic [CW-1:0] outs_cnt_reg [NUM_MST];
  logic          rid_err_reg;

  logic [NUM_MST-1:0] elig;
  logic               pick_found;
  logic [MW-1:0]      pick_idx;
  logic [MW:0]        cand;
  logic [MW-1:0]      cand_idx;
`ifdef AXI_ARB_QOS_EN
  logic [3:0]         best_qos;
`endif
  logic               ar_fire;

  logic [MW-1:0]      r_idx;
  logic               r_idx_ok;
  logic               r_beat;
  logic               r_done;
  logic [NUM_MST-1:0] cnt_inc;
  logic [NUM_MST-1:0] cnt_dec_req;
  logic [NUM_MST-1:0] cnt_undf;

  // R path decode: the RID prefix selects the upstream master
  assign r_idx    = m_rid[MW+IDW-1:IDW];
  assign r_idx_ok = ({1'b0, r_idx} < (MW+1)'(NUM_MST));
  // An out-of-range index is drained so the downstream port never locks up
  assign m_rready = r_idx_ok ? s_rready[r_idx] : 1'b1;
  assign r_beat   = m_rvalid && m_rready;
  assign r_done   = r_beat && m_rlast && r_idx_ok;

  assign s_rdata  = m_rdata;
  assign s_rid    = m_rid[IDW-1:0];
  assign s_rresp  = m_rresp;
  assign s_rlast  = m_rlast;
  assign rid_err  = rid_err_reg;

  // Granted master's request is muxed straight through while in GRANT
  assign m_araddr = s_araddr[gnt_reg*AW +: AW];
  assign m_arid   = {gnt_reg, s_arid[gnt_reg*IDW +: IDW]};
  assign m_arlen  = s_arlen[gnt_reg*8 +: 8];
`ifdef AXI_ARB_QOS_EN
  assign m_arqos  = s_arqos[gnt_reg*4 +: 4];
`endif

  // Per-master eligibility, handshake steering and outstanding counters
  for (genvar gi = 0; gi < NUM_MST; gi++) begin : g_mst
    assign elig[gi]        = s_arvalid[gi] && (outs_cnt_reg[gi] < CW'(MAX_OUTS));
    assign s_arready[gi]   = (state_reg == GRANT) && (gnt_reg == MW'(gi)) && m_arready;
    assign s_rvalid[gi]    = m_rvalid && r_idx_ok && (r_idx == MW'(gi));
    assign cnt_inc[gi]     = ar_fire && (gnt_reg == MW'(gi));
    assign cnt_dec_req[gi] = r_done && (r_idx == MW'(gi));
    assign cnt_undf[gi]    = cnt_dec_req[gi] && (outs_cnt_reg[gi] == '0);

    // Saturating counter; simultaneous issue and completion cancel out
    always_ff @(posedge clk) begin
      if (rst) begin
        outs_cnt_reg[gi] <= '0;
      end else if (cnt_inc[gi] && !(cnt_dec_req[gi] && !cnt_undf[gi])) begin
        if (outs_cnt_reg[gi] != CW'(MAX_OUTS))
          outs_cnt_reg[gi] <= outs_cnt_reg[gi] + 1'b1;
      end else if (cnt_dec_req[gi] && !cnt_undf[gi] && !cnt_inc[gi]) begin
        outs_cnt_reg[gi] <= outs_cnt_reg[gi] - 1'b1;
      end
    end
  end

  // Arbitration: scan from rr_ptr with wrap, first eligible (or best QoS) wins
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    cand_idx   = '0;
`ifdef AXI_ARB_QOS_EN
    best_qos   = '0;
`endif
    for (int k = 0; k < NUM_MST; k++) begin
      cand = {1'b0, rr_ptr_reg} + (MW+1)'(k);
      if (cand >= (MW+1)'(NUM_MST))
        cand = cand - (MW+1)'(NUM_MST);
      cand_idx = cand[MW-1:0];
`ifdef AXI_ARB_QOS_EN
      // Strict '>' keeps the earliest round-robin candidate on a QoS tie
      if (elig[cand_idx] && (!pick_found || (s_arqos[cand_idx*4 +: 4] > best_qos))) begin
        pick_found = 1'b1;
        pick_idx   = cand_idx;
        best_qos   = s_arqos[cand_idx*4 +: 4];
      end
`else
      if (!pick_found && elig[cand_idx]) begin
        pick_found = 1'b1;
        pick_idx   = cand_idx;
      end
`endif
    end
  end

  // FSM next state and AR outputs; grant is held until the handshake
  always_comb begin
    state_next  = state_reg;
    gnt_next    = gnt_reg;
    rr_ptr_next = rr_ptr_reg;
    m_arvalid   = 1'b0;
    ar_fire     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (pick_found) begin
          gnt_next   = pick_idx;
          state_next = GRANT;
        end
      end
      GRANT: begin
        m_arvalid = 1'b1;
        if (m_arready) begin
          ar_fire     = 1'b1;
          rr_ptr_next = (gnt_reg == MW'(NUM_MST - 1)) ? '0 : gnt_reg + 1'b1;
          state_next  = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // FSM state, grant, round-robin pointer and error pulse registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      gnt_reg     <= '0;
      rr_ptr_reg  <= '0;
      rid_err_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      gnt_reg     <= gnt_next;
      rr_ptr_reg  <= rr_ptr_next;
      rid_err_reg <= (r_beat && !r_idx_ok) || (|cnt_undf);
    end
  end

endmodule

// File: tb/tb_axi4_rd_arbiter.sv
// Scoreboard bench for axi4_rd_arbiter: directed stimulus pushes expected AR
// and R transactions into queues, a negedge monitor pops and compares them.
module tb_axi4_rd_arbiter;

  localparam int AW = 32;
  localparam int DW = 64;
  localparam int IDW = 4;

  typedef struct packed {logic [5:0] id; logic [31:0] addr; logic [7:0] len;} ar_t;
  typedef struct packed {logic [1:0] mst; logic [63:0] data; logic [3:0] rid; logic last;} r_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // DUT A: 4 masters
  logic [3:0]   s_arvalid = '0;
  logic [127:0] s_araddr = '0;
  logic [15:0]  s_arid = '0;
  logic [31:0]  s_arlen = '0;
  logic [3:0]   s_arready, s_rvalid;
  logic [63:0]  s_rdata;
  logic [3:0]   s_rid;
  logic [1:0]   s_rresp;
  logic         s_rlast;
  logic [3:0]   s_rready = '0;
  logic         m_arvalid;
  logic [31:0]  m_araddr;
  logic [5:0]   m_arid;
  logic [7:0]   m_arlen;
  logic         m_arready = 1'b0;
  logic         m_rvalid = 1'b0;
  logic [63:0]  m_rdata = '0;
  logic [5:0]   m_rid = '0;
  logic [1:0]   m_rresp = '0;
  logic         m_rlast = 1'b0;
  logic         m_rready;
  logic         rid_err;
`ifdef AXI_ARB_QOS_EN
  logic [15:0]  s_arqos = '0;
  logic [3:0]   m_arqos;
  logic [11:0]  b_s_arqos = '0;
  logic [3:0]   b_m_arqos;
`endif

  // DUT B: 3 masters, so RID index 3 is out of range
  logic [2:0]   b_s_arready, b_s_rvalid;
  logic [63:0]  b_s_rdata;
  logic [3:0]   b_s_rid;
  logic [1:0]   b_s_rresp;
  logic         b_s_rlast;
  logic [2:0]   b_s_rready = '0;
  logic         b_m_arvalid;
  logic [31:0]  b_m_araddr;
  logic [5:0]   b_m_arid;
  logic [7:0]   b_m_arlen;
  logic         b_m_rvalid = 1'b0;
  logic [5:0]   b_m_rid = '0;
  logic         b_m_rlast = 1'b0;
  logic         b_m_rready;
  logic         b_rid_err;

  axi4_rd_arbiter #(.NUM_MST(4), .AW(AW), .DW(DW), .IDW(IDW), .MAX_OUTS(4)) dut (
    .clk(clk), .rst(rst),
    .s_arvalid(s_arvalid), .s_araddr(s_araddr), .s_arid(s_arid), .s_arlen(s_arlen),
`ifdef AXI_ARB_QOS_EN
    .s_arqos(s_arqos), .m_arqos(m_arqos),
`endif
    .s_arready(s_arready), .s_rvalid(s_rvalid), .s_rdata(s_rdata), .s_rid(s_rid),
    .s_rresp(s_rresp), .s_rlast(s_rlast), .s_rready(s_rready),
    .m_arvalid(m_arvalid), .m_araddr(m_araddr), .m_arid(m_arid), .m_arlen(m_arlen),
    .m_arready(m_arready), .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_rid(m_rid),
    .m_rresp(m_rresp), .m_rlast(m_rlast), .m_rready(m_rready), .rid_err(rid_err)
  );

  axi4_rd_arbiter #(.NUM_MST(3), .AW(AW), .DW(DW), .IDW(IDW), .MAX_OUTS(4)) dut_b (
    .clk(clk), .rst(rst),
    .s_arvalid(3'b000), .s_araddr(96'h0), .s_arid(12'h0), .s_arlen(24'h0),
`ifdef AXI_ARB_QOS_EN
    .s_arqos(b_s_arqos), .m_arqos(b_m_arqos),
`endif
    .s_arready(b_s_arready), .s_rvalid(b_s_rvalid), .s_rdata(b_s_rdata), .s_rid(b_s_rid),
    .s_rresp(b_s_rresp), .s_rlast(b_s_rlast), .s_rready(b_s_rready),
    .m_arvalid(b_m_arvalid), .m_araddr(b_m_araddr), .m_arid(b_m_arid), .m_arlen(b_m_arlen),
    .m_arready(1'b0), .m_rvalid(b_m_rvalid), .m_rdata(64'h0), .m_rid(b_m_rid),
    .m_rresp(2'b00), .m_rlast(b_m_rlast), .m_rready(b_m_rready), .rid_err(b_rid_err)
  );

  ar_t ar_exp_q[$];
  r_t  r_exp_q[$];
  int  checks = 0;
  int  fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    fails++;
    $display("FAIL %s: event missing or unexpected", name);
  endtask

  task automatic exp_ar(input logic [1:0] m, input logic [3:0] id, input logic [31:0] addr,
                        input logic [7:0] len);
    ar_t t;
    t.id = {m, id}; t.addr = addr; t.len = len;
    ar_exp_q.push_back(t);
  endtask

  task automatic exp_r(input logic [1:0] m, input logic [63:0] data, input logic [3:0] rid,
                       input logic last);
    r_t t;
    t.mst = m; t.data = data; t.rid = rid; t.last = last;
    r_exp_q.push_back(t);
  endtask

  // Wait for the AR handshake of master i, then drop its valid
  task automatic wait_ar(input int i);
    bit ok = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (s_arready[i]) begin ok = 1'b1; break; end
    end
    if (!ok) fail_now("ar_timeout");
    @(posedge clk); #1;
    s_arvalid[i] = 1'b0;
  endtask

  task automatic issue_ar(input int i, input logic [31:0] addr, input logic [3:0] id,
                          input logic [7:0] len);
    s_araddr[i*AW +: AW] = addr;
    s_arid[i*IDW +: IDW] = id;
    s_arlen[i*8 +: 8]    = len;
    s_arvalid[i]         = 1'b1;
    wait_ar(i);
  endtask

  task automatic r_beat(input logic [5:0] rid, input logic [63:0] data, input logic last);
    bit ok = 1'b0;
    m_rid = rid; m_rdata = data; m_rlast = last; m_rresp = 2'b01; m_rvalid = 1'b1;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (m_rready) begin ok = 1'b1; break; end
    end
    if (!ok) fail_now("r_timeout");
    @(posedge clk); #1;
    m_rvalid = 1'b0; m_rlast = 1'b0;
  endtask

  // Monitor: every AR handshake and every delivered R beat must match the queue head
  task automatic monitor();
    ar_t ea;
    r_t  er;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (m_arvalid && m_arready) begin
          if (ar_exp_q.size() == 0) fail_now("ar_unexpected");
          else begin
            ea = ar_exp_q.pop_front();
            chk("ar_id", m_arid, ea.id);
            chk("ar_addr", m_araddr, ea.addr);
            chk("ar_len", m_arlen, ea.len);
          end
        end
        for (int i = 0; i < 4; i++) begin
          if (s_rvalid[i] && s_rready[i]) begin
            if (r_exp_q.size() == 0) fail_now("r_unexpected");
            else begin
              er = r_exp_q.pop_front();
              chk("r_mst", i, er.mst);
              chk("r_data", s_rdata, er.data);
              chk("r_rid", s_rid, er.rid);
              chk("r_last", s_rlast, er.last);
              chk("r_resp", s_rresp, 2'b01);
            end
          end
        end
      end
    end
  endtask

  int hi_cnt;

  initial begin
    fork monitor(); join_none

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_m_arvalid", m_arvalid, 0);
    chk("rst_s_arready", s_arready, 0);
    chk("rst_rid_err", rid_err, 0);
    @(posedge clk); #1;
    rst = 1'b0; m_arready = 1'b1; s_rready = 4'hF;

    // 1: masters 0 and 2 together from rr_ptr=0 -> 0 then 2
    exp_ar(2'd0, 4'h3, 32'h0000_1000, 8'd0);
    exp_ar(2'd2, 4'h5, 32'h0000_2000, 8'd1);
    fork
      issue_ar(0, 32'h0000_1000, 4'h3, 8'd0);
      issue_ar(2, 32'h0000_2000, 4'h5, 8'd1);
    join
    // rr_ptr is now 3: masters 1 and 3 together -> 3 then 1
    exp_ar(2'd3, 4'hA, 32'h0000_3300, 8'd2);
    exp_ar(2'd1, 4'hB, 32'h0000_1100, 8'd0);
    fork
      issue_ar(3, 32'h0000_3300, 4'hA, 8'd2);
      issue_ar(1, 32'h0000_1100, 4'hB, 8'd0);
    join

    // 2: master 1 fills to 4 outstanding, 5th waits for a completion
    for (int n = 0; n < 3; n++) begin
      exp_ar(2'd1, 4'(n), 32'h0000_1200 + 32'(n), 8'd0);
      issue_ar(1, 32'h0000_1200 + 32'(n), 4'(n), 8'd0);
    end
    s_araddr[1*AW +: AW] = 32'h0000_1F00; s_arid[1*IDW +: IDW] = 4'hE; s_arlen[8 +: 8] = 8'd7;
    s_arvalid[1] = 1'b1;
    hi_cnt = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (m_arvalid) hi_cnt++;
    end
    chk("limit_blocks_5th", hi_cnt, 0);
    @(posedge clk); #1;
    exp_r(2'd1, 64'hDEAD_0001, 4'h7, 1'b1);
    exp_ar(2'd1, 4'hE, 32'h0000_1F00, 8'd7);
    r_beat({2'd1, 4'h7}, 64'hDEAD_0001, 1'b1);
    wait_ar(1);

    // 3: 4-beat burst to master 2 with a 2-cycle upstream stall
    exp_ar(2'd2, 4'h5, 32'h0000_2400, 8'd3);
    issue_ar(2, 32'h0000_2400, 4'h5, 8'd3);
    for (int b = 0; b < 4; b++) exp_r(2'd2, 64'hB0B0_0000 + 64'(b), 4'h5, b == 3);
    s_rready = 4'b1011;
    m_rid = {2'd2, 4'h5}; m_rdata = 64'hB0B0_0000; m_rlast = 1'b0; m_rresp = 2'b01; m_rvalid = 1'b1;
    @(negedge clk);
    chk("stall_s_rvalid", s_rvalid, 4'b0100);
    chk("stall_m_rready", m_rready, 0);
    chk("stall_s_rid", s_rid, 4'h5);
    @(posedge clk); #1;
    @(negedge clk);
    chk("stall2_m_rready", m_rready, 0);
    @(posedge clk); #1;
    s_rready = 4'hF;
    for (int b = 0; b < 4; b++) r_beat({2'd2, 4'h5}, 64'hB0B0_0000 + 64'(b), b == 3);

    // 4: out-of-range RID on the 3-master instance is drained and flagged
    b_m_rid = {2'd3, 4'h0}; b_m_rvalid = 1'b1;
    @(negedge clk);
    chk("badid_m_rready", b_m_rready, 1);
    chk("badid_s_rvalid", b_s_rvalid, 0);
    chk("badid_err_before", b_rid_err, 0);
    @(posedge clk); #1;
    b_m_rvalid = 1'b0;
    @(negedge clk);
    chk("badid_err_pulse", b_rid_err, 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("badid_err_clear", b_rid_err, 0);
    // completion with nothing outstanding is ignored and flagged
    b_m_rid = {2'd1, 4'h0}; b_m_rlast = 1'b1; b_s_rready = 3'b010; b_m_rvalid = 1'b1;
    @(negedge clk);
    chk("undf_s_rvalid", b_s_rvalid, 3'b010);
    @(posedge clk); #1;
    b_m_rvalid = 1'b0; b_m_rlast = 1'b0;
    @(negedge clk);
    chk("undf_err_pulse", b_rid_err, 1);

    // 5: reset while GRANT is stalled clears the grant and the counters
    @(posedge clk); #1;
    m_arready = 1'b0;
    s_araddr[0 +: AW] = 32'h0000_0500; s_arvalid[0] = 1'b1;
    hi_cnt = 0;
    for (int c = 0; c < 10 && hi_cnt == 0; c++) begin
      @(negedge clk);
      if (m_arvalid) hi_cnt++;
    end
    chk("grant_reached", hi_cnt, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_grant_m_arvalid", m_arvalid, 0);
    chk("rst_grant_s_arready", s_arready, 0);
    @(posedge clk); #1;
    s_arvalid[0] = 1'b0; rst = 1'b0; m_arready = 1'b1;
    // master 1 was at its limit before reset; it must be granted now
    exp_ar(2'd1, 4'h9, 32'h0000_1900, 8'd0);
    issue_ar(1, 32'h0000_1900, 4'h9, 8'd0);

`ifdef AXI_ARB_QOS_EN
    // 6: QoS wins over round-robin (rr_ptr=2 here), ties stay round-robin
    s_arqos = 16'h0092;
    exp_ar(2'd1, 4'h1, 32'h0000_6100, 8'd0);
    exp_ar(2'd0, 4'h0, 32'h0000_6000, 8'd0);
    fork
      issue_ar(0, 32'h0000_6000, 4'h0, 8'd0);
      issue_ar(1, 32'h0000_6100, 4'h1, 8'd0);
    join
    s_arqos = 16'h0404;
    exp_ar(2'd2, 4'h2, 32'h0000_6200, 8'd0);
    exp_ar(2'd0, 4'h3, 32'h0000_6300, 8'd0);
    fork
      issue_ar(0, 32'h0000_6300, 4'h3, 8'd0);
      issue_ar(2, 32'h0000_6200, 4'h2, 8'd0);
    join
`endif

    repeat (5) @(posedge clk);
    chk("ar_queue_drained", ar_exp_q.size(), 0);
    chk("r_queue_drained", r_exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
